// File: rtl/id_ex_control_stage_pkg.sv
// Shared definitions for the ID/EX control stage: opcodes, ALUOp codes and
// the packed control bundle carried from decode into EX.
package id_ex_control_stage_pkg;

  // Major opcodes (instr[6:0]) understood by the main control decoder.
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // ALUOp codes consumed by the EX-stage ALU control decoder.
  localparam logic [1:0] ALUOP_MEM = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;

  // Control bundle produced by decode and registered into EX.
  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       memto_reg;
    logic       branch;
  } ctrl_t;

  // All-zero bundle: what a bubble looks like in EX.
  localparam ctrl_t CTRL_NONE = '0;

endpackage

// File: rtl/id_ex_control_stage_decoder.sv
// Main control decoder: pure combinational opcode-to-control-bundle mapping.
// Unknown opcodes produce an all-zero bundle and legal = 0 so the stage can
// turn them into bubbles.
module main_control_decoder
  import id_ex_control_stage_pkg::*;
(
  input  logic [6:0] opcode,
  output ctrl_t      ctrl,
  output logic       legal
);

  // Decode the major opcode into the control bundle.
  always_comb begin
    ctrl  = CTRL_NONE;
    legal = 1'b1;
    case (opcode)
      OP_RTYPE: begin
        ctrl.alu_op    = ALUOP_R;
        ctrl.reg_write = 1'b1;
      end
      OP_LOAD: begin
        ctrl.alu_op    = ALUOP_MEM;
        ctrl.alu_src   = 1'b1;
        ctrl.mem_read  = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.memto_reg = 1'b1;
      end
      OP_STORE: begin
        ctrl.alu_op    = ALUOP_MEM;
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      OP_ITYPE: begin
        ctrl.alu_op    = ALUOP_MEM;
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      OP_BRANCH: begin
        ctrl.alu_op = ALUOP_BR;
        ctrl.branch = 1'b1;
      end
      default: begin
        ctrl  = CTRL_NONE;
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/id_ex_control_stage.sv
// ID/EX control stage: decodes the IF/ID instruction, detects load-use
// hazards, and registers controls plus register indices into EX.
//
// Pipeline-slot semantics: ex_valid = 1 means EX holds a real instruction.
// When pc_write/ifid_write are 0 the front end must hold PC and IF/ID, and
// this stage loads a bubble (ex_valid = 0, all controls and indices 0).
// Because the bubble clears ex_MemRead, a load-use stall lasts one cycle.
module id_ex_control_stage
  import id_ex_control_stage_pkg::*;
#(
  parameter int STALL_CNT_W = 16,
  parameter int XLEN        = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            id_instr,
  input  logic                   id_valid,
  input  logic                   flush,
  output logic                   pc_write,
  output logic                   ifid_write,
  output logic                   ex_valid,
  output logic [1:0]             ex_ALUOp,
  output logic [3:0]             ex_Funct,
  output logic                   ex_ALUSrc,
  output logic                   ex_MemRead,
  output logic                   ex_MemWrite,
  output logic                   ex_RegWrite,
  output logic                   ex_MemtoReg,
  output logic                   ex_Branch,
  output logic [4:0]             ex_rs1,
  output logic [4:0]             ex_rs2,
  output logic [4:0]             ex_rd,
  output logic [STALL_CNT_W-1:0] stall_count
);

  // The datapath width is fixed (ld/sd are doubleword); it does not change
  // any control decision here.
  localparam int unused_xlen = XLEN;

  ctrl_t      id_ctrl;
  logic       id_legal;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic [4:0] id_rd;
  logic [3:0] id_funct;
  logic       hazard;
  logic       load_bubble;

  // Instruction bits not consumed by control (upper funct7 / imm bits).
  logic unused_bits;
  assign unused_bits = &{1'b0, id_instr[31], id_instr[29:25]};

  main_control_decoder u_decoder (
    .opcode (id_instr[6:0]),
    .ctrl   (id_ctrl),
    .legal  (id_legal)
  );

  // Register fields. rs2 is taken from [24:20] even for ld/I-type, which
  // makes the hazard check conservative for those opcodes.
  assign id_rs1   = id_instr[19:15];
  assign id_rs2   = id_instr[24:20];
  assign id_rd    = id_instr[11:7];
  assign id_funct = {id_instr[30], id_instr[14:12]};

  // Load-use hazard: a valid load in EX writes a nonzero register that the
  // valid ID instruction reads.
  always_comb begin
    hazard = ex_valid & ex_MemRead & (ex_rd != 5'd0) & id_valid &
             ((ex_rd == id_rs1) | (ex_rd == id_rs2));
  end

  assign pc_write    = ~hazard;
  assign ifid_write  = ~hazard;
  assign load_bubble = flush | hazard | ~id_valid | ~id_legal;

  // ID/EX register: bubble on flush, stall, empty ID or unknown opcode.
  always_ff @(posedge clk) begin
    if (reset || load_bubble) begin
      ex_valid    <= 1'b0;
      ex_ALUOp    <= 2'b00;
      ex_Funct    <= 4'b0000;
      ex_ALUSrc   <= 1'b0;
      ex_MemRead  <= 1'b0;
      ex_MemWrite <= 1'b0;
      ex_RegWrite <= 1'b0;
      ex_MemtoReg <= 1'b0;
      ex_Branch   <= 1'b0;
      ex_rs1      <= 5'd0;
      ex_rs2      <= 5'd0;
      ex_rd       <= 5'd0;
    end else begin
      ex_valid    <= 1'b1;
      ex_ALUOp    <= id_ctrl.alu_op;
      ex_Funct    <= id_funct;
      ex_ALUSrc   <= id_ctrl.alu_src;
      ex_MemRead  <= id_ctrl.mem_read;
      ex_MemWrite <= id_ctrl.mem_write;
      ex_RegWrite <= id_ctrl.reg_write;
      ex_MemtoReg <= id_ctrl.memto_reg;
      ex_Branch   <= id_ctrl.branch;
      ex_rs1      <= id_rs1;
      ex_rs2      <= id_rs2;
      ex_rd       <= id_rd;
    end
  end

  // Saturating count of load-use stalls; a flushed stall is not counted.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count <= '0;
    end else if (hazard && !flush && (stall_count != {STALL_CNT_W{1'b1}})) begin
      stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_id_ex_control_stage.sv
// Testbench for id_ex_control_stage: directed and random instruction streams
// checked against a pipeline-slot reference model through expected queues.
module tb_id_ex_control_stage;

  localparam int CW      = 2;
  localparam int CNT_MAX = (1 << CW) - 1;
  localparam int EW      = 28 + CW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [31:0]   id_instr;
  logic          id_valid;
  logic          flush;
  logic          pc_write;
  logic          ifid_write;
  logic          ex_valid;
  logic [1:0]    ex_ALUOp;
  logic [3:0]    ex_Funct;
  logic          ex_ALUSrc;
  logic          ex_MemRead;
  logic          ex_MemWrite;
  logic          ex_RegWrite;
  logic          ex_MemtoReg;
  logic          ex_Branch;
  logic [4:0]    ex_rs1;
  logic [4:0]    ex_rs2;
  logic [4:0]    ex_rd;
  logic [CW-1:0] stall_count;

  id_ex_control_stage #(.STALL_CNT_W(CW), .XLEN(64)) dut (
    .clk         (clk),
    .reset       (reset),
    .id_instr    (id_instr),
    .id_valid    (id_valid),
    .flush       (flush),
    .pc_write    (pc_write),
    .ifid_write  (ifid_write),
    .ex_valid    (ex_valid),
    .ex_ALUOp    (ex_ALUOp),
    .ex_Funct    (ex_Funct),
    .ex_ALUSrc   (ex_ALUSrc),
    .ex_MemRead  (ex_MemRead),
    .ex_MemWrite (ex_MemWrite),
    .ex_RegWrite (ex_RegWrite),
    .ex_MemtoReg (ex_MemtoReg),
    .ex_Branch   (ex_Branch),
    .ex_rs1      (ex_rs1),
    .ex_rs2      (ex_rs2),
    .ex_rd       (ex_rd),
    .stall_count (stall_count)
  );

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  logic [1:0]    stall_q[$];
  int checks = 0;
  int passed = 0;
  int cycle  = 0;

  // Reference model of what currently sits in EX.
  logic       m_valid;
  logic       m_memread;
  logic [4:0] m_rd;
  int         m_cnt;

  task automatic check_val(input string name, input logic [EW-1:0] got,
                           input logic [EW-1:0] want);
    checks++;
    if (got !== want)
      $display("FAIL %s cycle %0d: got %h required %h", name, cycle, got, want);
    else
      passed++;
  endtask

  // ---------------- instruction builders ----------------
  function automatic logic [31:0] r_ins(input logic b30, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {1'b0, b30, 5'b0, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] i_ins(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  // ---------------- driver ----------------
  // Drives one ID cycle and pushes the expected stall outputs for this cycle
  // and the expected EX contents after the following clock edge.
  task automatic drive(input logic [31:0] instr, input logic v, input logic fl,
                       input logic rst);
    logic       haz;
    logic       legal;
    logic       load;
    logic [1:0] aop;
    logic [5:0] flags; // alusrc, memread, memwrite, regwrite, memtoreg, branch
    logic [4:0] rs1, rs2, rd;
    logic [EW-1:0] e;
    @(negedge clk);
    cycle++;
    id_instr = instr;
    id_valid = v;
    flush    = fl;
    reset    = rst;
    rs1 = instr[19:15];
    rs2 = instr[24:20];
    rd  = instr[11:7];
    haz = m_valid && m_memread && (m_rd != 5'd0) && v && (m_rd == rs1 || m_rd == rs2);
    legal = 1'b1;
    aop   = 2'b00;
    flags = 6'b000000;
    case (instr[6:0])
      7'b0110011: begin aop = 2'b10; flags = 6'b000100; end
      7'b0000011: begin aop = 2'b00; flags = 6'b110110; end
      7'b0100011: begin aop = 2'b00; flags = 6'b101000; end
      7'b0010011: begin aop = 2'b00; flags = 6'b100100; end
      7'b1100011: begin aop = 2'b01; flags = 6'b000001; end
      default:    legal = 1'b0;
    endcase
    stall_q.push_back({~haz, ~haz});
    if (rst) begin
      m_cnt = 0;
      load  = 1'b0;
    end else begin
      if (haz && !fl && m_cnt < CNT_MAX) m_cnt++;
      load = !(fl || haz || !v || !legal);
    end
    if (load) begin
      e = {1'b1, aop, instr[30], instr[14:12], flags, rs1, rs2, rd, m_cnt[CW-1:0]};
      m_valid   = 1'b1;
      m_memread = flags[4];
      m_rd      = rd;
    end else begin
      e = {28'b0, m_cnt[CW-1:0]};
      m_valid   = 1'b0;
      m_memread = 1'b0;
      m_rd      = 5'd0;
    end
    exp_q.push_back(e);
  endtask

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (stall_q.size() > 0)
        check_val("stall_outputs", {{(EW-2){1'b0}}, pc_write, ifid_write},
                  {{(EW-2){1'b0}}, stall_q.pop_front()});
      @(posedge clk);
      #1;
      if (exp_q.size() > 0)
        check_val("ex_register",
                  {ex_valid, ex_ALUOp, ex_Funct, ex_ALUSrc, ex_MemRead, ex_MemWrite,
                   ex_RegWrite, ex_MemtoReg, ex_Branch, ex_rs1, ex_rs2, ex_rd,
                   stall_count},
                  exp_q.pop_front());
    end
  end

  // ---------------- stimulus ----------------
  logic [31:0] ld_x1, add_use, ld_x0, add_x0, rnd;
  logic [6:0]  ops[6];

  initial begin
    reset    = 1'b1;
    id_instr = 32'd0;
    id_valid = 1'b0;
    flush    = 1'b0;
    repeat (2) @(posedge clk);
    m_valid = 1'b0; m_memread = 1'b0; m_rd = 5'd0; m_cnt = 0;

    ld_x1   = i_ins(12'd0, 5'd2, 3'b011, 5'd1, 7'b0000011);
    add_use = r_ins(1'b0, 5'd5, 5'd1, 3'b000, 5'd4);
    ld_x0   = i_ins(12'd0, 5'd2, 3'b011, 5'd0, 7'b0000011);
    add_x0  = r_ins(1'b0, 5'd5, 5'd0, 3'b000, 5'd4);

    // Release reset with an empty ID slot.
    drive(32'd0, 1'b0, 1'b0, 1'b0);
    // sub x5,x6,x7
    drive(r_ins(1'b1, 5'd7, 5'd6, 3'b000, 5'd5), 1'b1, 1'b0, 1'b0);
    // slli x3,x3,3 then ld x1,0(x2)
    drive(i_ins(12'd3, 5'd3, 3'b001, 5'd3, 7'b0010011), 1'b1, 1'b0, 1'b0);
    drive(ld_x1, 1'b1, 1'b0, 1'b0);
    drive(32'd0, 1'b0, 1'b0, 1'b0);
    // Load-use: ld x1 then add x4,x1,x5 held in IF/ID for the stall cycle.
    drive(ld_x1, 1'b1, 1'b0, 1'b0);
    drive(add_use, 1'b1, 1'b0, 1'b0);
    drive(add_use, 1'b1, 1'b0, 1'b0);
    drive(32'd0, 1'b0, 1'b0, 1'b0);
    // ld x0 then use of x0: no stall.
    drive(ld_x0, 1'b1, 1'b0, 1'b0);
    drive(add_x0, 1'b1, 1'b0, 1'b0);
    // ld x1 then use with flush on the hazard cycle.
    drive(ld_x1, 1'b1, 1'b0, 1'b0);
    drive(add_use, 1'b1, 1'b1, 1'b0);
    drive(32'd0, 1'b0, 1'b0, 1'b0);
    // Reset arriving during a stall.
    drive(ld_x1, 1'b1, 1'b0, 1'b0);
    drive(add_use, 1'b1, 1'b0, 1'b1);
    drive(add_use, 1'b1, 1'b0, 1'b0);
    // Drive more hazards than the counter can hold.
    for (int i = 0; i < CNT_MAX + 3; i++) begin
      drive(ld_x1, 1'b1, 1'b0, 1'b0);
      drive(add_use, 1'b1, 1'b0, 1'b0);
      drive(add_use, 1'b1, 1'b0, 1'b0);
    end

    // Random streams with small register indices so hazards are frequent.
    ops[0] = 7'b0110011; ops[1] = 7'b0000011; ops[2] = 7'b0100011;
    ops[3] = 7'b0010011; ops[4] = 7'b1100011; ops[5] = 7'b1111111;
    for (int i = 0; i < 400; i++) begin
      rnd = $urandom;
      rnd[6:0]   = ops[$urandom_range(0, 5)];
      rnd[11:7]  = 5'($urandom_range(0, 3));
      rnd[19:15] = 5'($urandom_range(0, 3));
      rnd[24:20] = 5'($urandom_range(0, 3));
      if (rnd[6:0] == 7'b0000011) rnd[14:12] = 3'b011;
      drive(rnd, ($urandom_range(0, 9) != 0), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 49) == 0));
    end
    drive(32'd0, 1'b0, 1'b0, 1'b0);

    // Let the monitor drain, bounded.
    repeat (3) @(posedge clk);
    #3;
    if (exp_q.size() != 0 || stall_q.size() != 0) begin
      checks++;
      $display("FAIL drain: %0d ex and %0d stall expectations left, required 0",
               exp_q.size(), stall_q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
